// File: rtl/sm_run_ctrl.sv
// Run-control sequencer for sm_cpu: gates the core clock enable through HALT/RUN/STEP/BREAK.
// Breakpoint stop logic is built only when SM_RUN_CTRL_BREAKPOINT_EN is defined.
module sm_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int RUN_ON_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             cnt_clr,
  input  logic [31:0]      cpu_pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             step_done,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  localparam state_t RST_STATE = (RUN_ON_RST == 1) ? ST_RUN : ST_HALT;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             bp_hit_s;
  logic             skip_r;
  logic             skip_nxt_s;
  logic             step_done_r;
  logic             bp_hit_o_r;
  logic [CNT_W-1:0] cycle_cnt_r;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  // Breakpoint match; skip masks the first RUN cycle after resuming from BREAK.
  always_comb begin
    bp_hit_s = bp_valid & (cpu_pc == bp_addr) & ~skip_r & (state_r == ST_RUN);
  end
`else
  logic unused_bp_s;

  // Breakpoint inputs are accepted but have no effect in this build.
  always_comb begin
    bp_hit_s    = 1'b0;
    unused_bp_s = ^{cpu_pc, bp_addr, bp_valid, skip_r};
  end
`endif

  // Core enable: the breakpoint instruction itself is held, never executed.
  always_comb begin
    cpu_en = ((state_r == ST_RUN) & ~bp_hit_s) | (state_r == ST_STEP);
  end

  // Next-state decode; halt_req outranks step_req, which outranks run_req.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = 1'b0;
    case (state_r)
      ST_HALT: begin
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (step_req) begin
          state_nxt_s = ST_STEP;
        end else if (run_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (bp_hit_s) begin
          state_nxt_s = ST_BREAK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: begin
        state_nxt_s = ST_HALT;
      end
      ST_BREAK: begin
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (step_req) begin
          state_nxt_s = ST_STEP;
        end else if (run_req) begin
          state_nxt_s = ST_RUN;
          skip_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_BREAK;
        end
`else
        state_nxt_s = ST_HALT;
`endif
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // State, skip flag and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RST_STATE;
      skip_r      <= 1'b0;
      step_done_r <= 1'b0;
      bp_hit_o_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      skip_r      <= skip_nxt_s;
      step_done_r <= (state_r == ST_STEP);
      bp_hit_o_r  <= (state_r == ST_RUN) & (state_nxt_s == ST_BREAK);
    end
  end

  // Executed-cycle counter; clear wins over increment, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
    end else if (cpu_en) begin
      cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign state     = state_r;
  assign halted    = (state_r == ST_HALT) | (state_r == ST_BREAK);
  assign step_done = step_done_r;
  assign bp_hit_o  = bp_hit_o_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule
